// File: rtl/mul_unit.sv
// Iterative radix-2 multiply/accumulate unit owning the HI/LO pair.
// Signed ops multiply magnitudes and fix the sign afterwards; busy stalls the pipe until commit.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_wr,
  input  logic             lo_wr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_FIX, S_ACC} state_e;
  typedef enum logic [1:0] {C_MUL, C_ADD, C_SUB} cls_e;

  state_e             state_q;
  cls_e               cls_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [2*WIDTH-1:0] p_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;

  logic               is_signed;
  logic               op_ok;
  logic               neg_d;
  cls_e               cls_d;
  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] step_d;
  logic [2*WIDTH-1:0] acc_d;

  always_comb begin
    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    is_signed = ~op[0];
    op_ok     = (op <= 3'b101);
    mag_a_d   = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    mag_b_d   = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    neg_d     = is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
    cls_d     = C_MUL;
    case (op[2:1])
      2'b01:   cls_d = C_ADD;
      2'b10:   cls_d = C_SUB;
      default: cls_d = C_MUL;
    endcase

    // Multiplier sits in the low half and shifts out; the upper half needs a carry bit.
    sum_d  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    step_d = {sum_d, p_q[WIDTH-1:1]};

    acc_d = p_q;
    case (cls_q)
      C_ADD:   acc_d = {hi_q, lo_q} + p_q;
      C_SUB:   acc_d = {hi_q, lo_q} - p_q;
      default: acc_d = p_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_MUL;
      cnt_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && op_ok) begin
            state_q <= S_MULT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            a_q     <= mag_a_d;
            p_q     <= {{WIDTH{1'b0}}, mag_b_d};
            neg_q   <= neg_d;
            cls_q   <= cls_d;
          end else begin
            if (hi_wr) hi_q <= rs_val;
            if (lo_wr) lo_q <= rs_val;
          end
        end
        S_MULT: begin
          p_q   <= step_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (neg_q) p_q <= -p_q;
          state_q <= S_ACC;
        end
        S_ACC: begin
          {hi_q, lo_q} <= acc_d;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: directed corner cases plus random ops, checked against a 64-bit arithmetic model.
module tb_mul_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] m_hilo = '0;

  mul_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hi_wr(hi_wr), .lo_wr(lo_wr),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO value.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] p;
    if (o[0]) p = {32'd0, a} * {32'd0, b};
    else      p = 64'(longint'($signed(a)) * longint'($signed(b)));
    case (o[2:1])
      2'b00:   return p;
      2'b01:   return acc + p;
      default: return acc - p;
    endcase
  endfunction

  task automatic mt(input bit wh, input bit wl, input logic [31:0] v);
    hi_wr = wh; lo_wr = wl; rs_val = v;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b0;
    if (wh) m_hilo[63:32] = v;
    if (wl) m_hilo[31:0] = v;
    check("mt_hilo", {hi, lo}, m_hilo);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input bit wr_same, input bit end_pulse);
    logic [63:0] exp;
    int k;
    bit hold_ok;
    exp = model(o, a, b, m_hilo);
    start = 1'b1; op = o; rs_val = a; rt_val = b; hi_wr = wr_same; lo_wr = wr_same;
    tick();
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    rs_val = $urandom; rt_val = $urandom;
    k = 0;
    hold_ok = 1'b1;
    while (done !== 1'b1 && k < 100) begin
      if (busy !== 1'b1 || {hi, lo} !== m_hilo) hold_ok = 1'b0;
      if (k == poke_at) begin
        start = 1'b1; op = 3'b001; hi_wr = 1'b1; lo_wr = 1'b1;
        rs_val = $urandom; rt_val = $urandom;
      end else begin
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    check("latency", 64'(k), 64'd34);
    check("busy_and_hold", 64'(hold_ok), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("result", {hi, lo}, exp);
    m_hilo = exp;
    if (end_pulse) begin
      tick();
      check("done_pulse_width", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    logic [2:0] ro;
    bit seen_done;

    #1 Rst = 1'b1;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    Rst = 1'b0;
    tick();

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, -1, 1'b0, 1'b1);
    check("mult_7x-3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 1'b1);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 1'b1);
    check("mult_m1", {hi, lo}, 64'h0000_0000_0000_0001);

    mt(1'b0, 1'b1, 32'h10);
    mt(1'b1, 1'b0, 32'h0);
    run_op(3'b010, 32'd2, 32'd3, -1, 1'b0, 1'b1);
    check("madd_2x3", {hi, lo}, 64'h16);
    run_op(3'b100, 32'd4, 32'd5, -1, 1'b0, 1'b1);
    run_op(3'b100, 32'd1, 32'd4, -1, 1'b0, 1'b1);
    check("msub_below_zero", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, 1'b1);
    check("mult_minint", {hi, lo}, 64'h4000_0000_0000_0000);

    mt(1'b1, 1'b1, 32'hFFFF_FFFF);
    run_op(3'b011, 32'd1, 32'd1, -1, 1'b0, 1'b1);
    check("maddu_wrap", {hi, lo}, 64'd0);

    // Requests and mthi/mtlo during busy, and writes paired with an accepted start, are dropped.
    run_op(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b0, 1'b1);
    run_op(3'b000, 32'hDEAD_BEEF, 32'h0000_0123, -1, 1'b1, 1'b1);

    // Back-to-back: the second start is presented while done is high.
    run_op(3'b000, 32'd100, 32'd200, -1, 1'b0, 1'b0);
    run_op(3'b010, 32'hFFFF_FF00, 32'd3, -1, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 5));
      run_op(ro, $urandom, $urandom, (i % 4 == 0) ? int'($urandom_range(0, 33)) : -1, 1'b0, 1'b1);
    end

    // Reset in the middle of MULT aborts with HI/LO cleared and no done pulse.
    mt(1'b1, 1'b1, 32'hA5A5_5A5A);
    start = 1'b1; op = 3'b000; rs_val = 32'd9; rt_val = 32'd9;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    #1 Rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    #1 Rst = 1'b0;
    m_hilo = '0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy !== 1'b0) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_hilo_held", {hi, lo}, 64'd0);

    // Reserved opcode with start is ignored.
    run_op(3'b000, 32'h0000_FFFF, 32'h0001_0001, -1, 1'b0, 1'b1);
    start = 1'b1; op = 3'b110; rs_val = $urandom; rt_val = $urandom;
    tick();
    start = 1'b0;
    check("op110_busy", 64'(busy), 64'd0);
    tick();
    check("op110_done", 64'(done), 64'd0);
    check("op110_hilo", {hi, lo}, m_hilo);
    start = 1'b1; op = 3'b111;
    tick();
    start = 1'b0;
    check("op111_busy", 64'(busy), 64'd0);

    run_op(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, -1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
